// File: rtl/serial_rshifter.sv
// serial_rshifter
//   Multi-cycle right shifter/rotator. An operand is loaded on an accepted
//   start and shifted right one bit per clock. The mode can be logical,
//   arithmetic or rotate. The result is published with a one-cycle done
//   pulse and then held until the next completion.
//
// Ports
//   clk     system clock, rising edge
//   rst     synchronous, active-high reset
//   start   operation request, accepted only while busy=0 (IDLE or DONE)
//   src     operand, captured on acceptance
//   amt     right-shift amount, captured on acceptance
//   rotate  1 = rotate right, captured on acceptance
//   arith   1 = arithmetic shift (ignored when rotate=1), captured on acceptance
//   busy    high while shifting
//   done    one-cycle pulse on the cycle res is updated
//   res     result register
//
// state   | meaning
// S_IDLE  | waiting for start
// S_SHIFT | one bit per clock until the count reaches zero, then publish res
// S_DONE  | done pulse cycle; a new start is accepted here too
module serial_rshifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src,
  input  logic [AMT_W-1:0] amt,
  input  logic             rotate,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [AMT_W-1:0] cnt;
  logic             rot_q;
  logic             arith_q;
  logic             msb_in;

  // Rotate has priority over arithmetic. Logical mode fills with zero.
  always_comb begin
    msb_in = 1'b0;
    if (rot_q)        msb_in = sreg[0];
    else if (arith_q) msb_in = sreg[WIDTH-1];
  end

  assign busy = (state == S_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      sreg    <= '0;
      cnt     <= '0;
      rot_q   <= 1'b0;
      arith_q <= 1'b0;
      done    <= 1'b0;
      res     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            sreg    <= src;
            cnt     <= amt;
            rot_q   <= rotate;
            arith_q <= arith;
            state   <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (cnt != '0) begin
            sreg <= {msb_in, sreg[WIDTH-1:1]};
            cnt  <= cnt - 1'b1;
          end else begin
            // The count-zero cycle costs one clock. It publishes the result,
            // giving amt+1 busy cycles in total.
            res   <= sreg;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rshifter.sv
module tb_serial_rshifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] src;
  logic [3:0]  amt;
  logic        rotate;
  logic        arith;
  logic        busy;
  logic        done;
  logic [15:0] res;

  int n_vec  = 0;
  int n_miss = 0;

  serial_rshifter #(.WIDTH(16), .AMT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .amt(amt),
    .rotate(rotate), .arith(arith), .busy(busy), .done(done), .res(res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one operation from idle, then scramble the inputs. Measure the
  // latency and busy length, check that res held prev_res until done, and
  // check the result and the one-cycle pulse.
  task automatic run_op(input string tag, input logic [15:0] s, input logic [3:0] a,
                        input logic r, input logic ar,
                        input logic [15:0] exp_res, input logic [15:0] prev_res);
    int lat;
    int bc;
    logic got;
    logic held;
    lat = 0; bc = 0; got = 1'b0; held = 1'b1;
    @(negedge clk);
    start = 1'b1; src = s; amt = a; rotate = r; arith = ar;
    @(posedge clk);
    #1;
    start = 1'b0; src = ~s; amt = ~a; rotate = ~r; arith = ~ar;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bc++;
      if (res !== prev_res) held = 1'b0;
      @(posedge clk);
      lat++;
    end
    chk({tag, "/done_seen"}, 16'(got), 16'd1);
    chk({tag, "/latency"}, 16'(lat), 16'(a) + 16'd1);
    chk({tag, "/busy_cycles"}, 16'(bc), 16'(a) + 16'd1);
    chk({tag, "/res_held"}, 16'(held), 16'd1);
    chk({tag, "/res"}, res, exp_res);
    chk({tag, "/busy_at_done"}, 16'(busy), 16'd0);
    @(negedge clk);
    chk({tag, "/done_pulse_len"}, 16'(done), 16'd0);
    chk({tag, "/res_after"}, res, exp_res);
  endtask

  logic [15:0] b2b_src [3];
  logic [15:0] b2b_exp [3];

  initial begin
    int lat;
    int ndone;
    int c;
    int last;
    int k;
    logic held;
    logic got;

    rst = 1'b1; start = 1'b1; src = 16'hbeef; amt = 4'd2; rotate = 1'b0; arith = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset/busy", 16'(busy), 16'd0);
    chk("reset/done", 16'(done), 16'd0);
    chk("reset/res", res, 16'h0000);
    rst = 1'b0; start = 1'b0;

    run_op("t1_logical1",  16'h00d0, 4'd1,  1'b0, 1'b0, 16'h0068, 16'h0000);
    run_op("t2_rot15",     16'h000d, 4'd15, 1'b1, 1'b0, 16'h001a, 16'h0068);
    run_op("t3_arith2",    16'hc000, 4'd2,  1'b0, 1'b1, 16'hf000, 16'h001a);
    run_op("t3_logical2",  16'hc000, 4'd2,  1'b0, 1'b0, 16'h3000, 16'hf000);
    run_op("t4_amt0",      16'ha5a5, 4'd0,  1'b0, 1'b0, 16'ha5a5, 16'h3000);
    run_op("t4_rot_prio",  16'h8001, 4'd1,  1'b1, 1'b1, 16'hc000, 16'ha5a5);
    run_op("x_arith15",    16'h8000, 4'd15, 1'b0, 1'b1, 16'hffff, 16'hc000);
    run_op("x_logical15",  16'h8000, 4'd15, 1'b0, 1'b0, 16'h0001, 16'hffff);
    run_op("x_rot4",       16'h1234, 4'd4,  1'b1, 1'b0, 16'h4123, 16'h0001);

    // A start while busy must be ignored.
    @(negedge clk);
    start = 1'b1; src = 16'hffff; amt = 4'd8; rotate = 1'b0; arith = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; src = 16'h1234; amt = 4'd0; rotate = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; src = 16'h0000; rotate = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("t5_ignore/done_seen", 16'(got), 16'd1);
    chk("t5_ignore/res", res, 16'h00ff);
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("t5_ignore/no_extra_op", 16'(ndone), 16'd0);

    // A reset in mid-operation discards the operation.
    @(negedge clk);
    start = 1'b1; src = 16'h5555; amt = 4'd10;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst/busy", 16'(busy), 16'd0);
    chk("t5_rst/done", 16'(done), 16'd0);
    chk("t5_rst/res", res, 16'h0000);
    rst = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("t5_rst/no_done", 16'(ndone), 16'd0);

    // If rst and start arrive together, the start is dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; src = 16'h00f0; amt = 4'd1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start/busy", 16'(busy), 16'd0);
    @(negedge clk);
    chk("rst_start/still_idle", 16'(busy), 16'd0);

    // With start held high, one operation completes every amt+2 cycles.
    b2b_src[0] = 16'hf0f0; b2b_exp[0] = 16'h1e1e;
    b2b_src[1] = 16'h8008; b2b_exp[1] = 16'h1001;
    b2b_src[2] = 16'h0ff8; b2b_exp[2] = 16'h01ff;
    @(negedge clk);
    start = 1'b1; src = b2b_src[0]; amt = 4'd3; rotate = 1'b0; arith = 1'b0;
    @(posedge clk);
    c = 0; last = 0; k = 0; held = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (done) begin
        chk($sformatf("t6_b2b/res%0d", k), res, b2b_exp[k]);
        chk($sformatf("t6_b2b/busy%0d", k), 16'(busy), 16'd0);
        if (k == 0) chk("t6_b2b/first_latency", 16'(c), 16'd4);
        else        chk($sformatf("t6_b2b/period%0d", k), 16'(c - last), 16'd5);
        last = c;
        k++;
        if (k < 3) src = b2b_src[k];
        else begin
          start = 1'b0;
          break;
        end
      end else begin
        if (res !== ((k == 0) ? 16'h0000 : b2b_exp[k-1])) held = 1'b0;
      end
    end
    chk("t6_b2b/ops_done", 16'(k), 16'd3);
    chk("t6_b2b/res_held", 16'(held), 16'd1);
    @(negedge clk);
    chk("t6_b2b/idle_after", 16'(busy), 16'd0);
    chk("t6_b2b/res_final", res, 16'h01ff);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
